// File: rtl/nasti_mem_responder_if.sv
// NASTI memory-side bus bundle: AW/W/B/AR/R channels between a master and the
// memory responder. Clock and reset are carried separately.
interface nasti_mem_responder_if;
    logic         awvalid;
    logic         awready;
    logic [7:0]   awid;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awuser;
    logic [2:0]   awprot;
    logic [3:0]   awqos;
    logic [3:0]   awregion;
    logic         awlock;
    logic [3:0]   awcache;

    logic         wvalid;
    logic         wready;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic         wlast;
    logic         wuser;

    logic         bvalid;
    logic         bready;
    logic [7:0]   bid;
    logic [1:0]   bresp;
    logic         buser;

    logic         arvalid;
    logic         arready;
    logic [7:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         aruser;
    logic [2:0]   arprot;
    logic [3:0]   arqos;
    logic [3:0]   arregion;
    logic         arlock;
    logic [3:0]   arcache;

    logic         rvalid;
    logic         rready;
    logic [7:0]   rid;
    logic [127:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         ruser;

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
               awuser, awprot, awqos, awregion, awlock, awcache,
        output awready,
        input  wvalid, wdata, wstrb, wlast, wuser,
        output wready,
        output bvalid, bid, bresp, buser,
        input  bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst,
               aruser, arprot, arqos, arregion, arlock, arcache,
        output arready,
        output rvalid, rid, rdata, rresp, rlast, ruser,
        input  rready
    );

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
               awuser, awprot, awqos, awregion, awlock, awcache,
        input  awready,
        output wvalid, wdata, wstrb, wlast, wuser,
        input  wready,
        input  bvalid, bid, bresp, buser,
        output bready,
        output arvalid, arid, araddr, arlen, arsize, arburst,
               aruser, arprot, arqos, arregion, arlock, arcache,
        input  arready,
        input  rvalid, rid, rdata, rresp, rlast, ruser,
        output rready
    );
endinterface

// File: rtl/nasti_mem_responder.sv
// Single-outstanding NASTI memory responder backed by a 128-bit word array
// with byte-strobe writes and per-beat range/burst error reporting.
//
// state    | meaning
// IDLE     | waiting for AW or AR; prio_wr picks the winner on a collision
// WR_DATA  | accepting W beats until beat count reaches awlen
// WR_RESP  | presenting B until bready
// RD_FETCH | registering the word at the current beat address
// RD_DATA  | presenting R beat until rready
module nasti_mem_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024
) (
    input  logic                  clk_asic,
    input  logic                  rst_asic,
    nasti_mem_responder_if.slave  mem_nasti
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_RESP,
        RD_FETCH,
        RD_DATA
    } state_t;

    state_t         r_state;
    state_t         w_state_nx;

    logic           r_prio_wr;
    logic [7:0]     r_id;
    logic [31:0]    r_addr;
    logic [7:0]     r_len;
    logic [1:0]     r_burst;
    logic [7:0]     r_beat;
    logic           r_err_dec;
    logic           r_err_last;
    logic [1:0]     r_bresp;
    logic [1:0]     r_rresp;
    logic           r_rlast;
    logic [127:0]   r_rdata;
    logic [127:0]   r_mem [DEPTH_WORDS];

    logic           w_awready;
    logic           w_arready;
    logic           w_wready;
    logic           w_bvalid;
    logic           w_rvalid;
    logic           w_aw_hs;
    logic           w_ar_hs;
    logic           w_w_hs;
    logic           w_r_hs;
    logic           w_last_beat;
    logic           w_legal;
    logic           w_in_range;
    logic [31:0]    w_offset;
    logic [31:0]    w_addr_nx;
    logic [IDX_W-1:0] w_idx;
    logic           w_err_dec_nx;
    logic           w_err_last_nx;
    logic [1:0]     w_bresp_nx;
    logic           w_unused;

    // Range test on the full 32-bit offset so addresses below the base wrap
    // high and fail the depth compare as well as the base compare.
    assign w_offset    = r_addr - ADDR_BASE;
    assign w_idx       = w_offset[IDX_W+3:4];
    assign w_in_range  = (r_addr >= ADDR_BASE) && ((w_offset >> 4) < 32'(DEPTH_WORDS));
    assign w_legal     = (r_burst == BURST_FIXED) || (r_burst == BURST_INCR);
    assign w_addr_nx   = (r_burst == BURST_INCR) ? (r_addr + 32'd16) : r_addr;
    assign w_last_beat = (r_beat == r_len);

    assign w_aw_hs = mem_nasti.awvalid & w_awready;
    assign w_ar_hs = mem_nasti.arvalid & w_arready;
    assign w_w_hs  = mem_nasti.wvalid  & w_wready;
    assign w_r_hs  = mem_nasti.rready  & w_rvalid;

    assign w_err_dec_nx  = r_err_dec  | ~w_in_range;
    assign w_err_last_nx = r_err_last | (mem_nasti.wlast != w_last_beat);

    always_comb begin
        w_bresp_nx = RESP_OKAY;
        if (!w_legal) begin
            w_bresp_nx = RESP_SLVERR;
        end else if (w_err_dec_nx) begin
            w_bresp_nx = RESP_DECERR;
        end else if (w_err_last_nx) begin
            w_bresp_nx = RESP_SLVERR;
        end
    end

    always_ff @(posedge clk_asic) begin
        if (rst_asic) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_awready  = 1'b0;
        w_arready  = 1'b0;
        w_wready   = 1'b0;
        w_bvalid   = 1'b0;
        w_rvalid   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_prio_wr) begin
                    w_awready = 1'b1;
                    w_arready = ~mem_nasti.awvalid;
                end else begin
                    w_arready = 1'b1;
                    w_awready = ~mem_nasti.arvalid;
                end
                if (mem_nasti.awvalid && w_awready) begin
                    w_state_nx = WR_DATA;
                end else if (mem_nasti.arvalid && w_arready) begin
                    w_state_nx = RD_FETCH;
                end
            end
            WR_DATA: begin
                w_wready = 1'b1;
                if (mem_nasti.wvalid && w_last_beat) begin
                    w_state_nx = WR_RESP;
                end
            end
            WR_RESP: begin
                w_bvalid = 1'b1;
                if (mem_nasti.bready) begin
                    w_state_nx = IDLE;
                end
            end
            RD_FETCH: begin
                w_state_nx = RD_DATA;
            end
            RD_DATA: begin
                w_rvalid = 1'b1;
                if (mem_nasti.rready) begin
                    w_state_nx = r_rlast ? IDLE : RD_FETCH;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_asic) begin
        if (rst_asic) begin
            r_prio_wr  <= 1'b1;
            r_id       <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_burst    <= '0;
            r_beat     <= '0;
            r_err_dec  <= 1'b0;
            r_err_last <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_rresp    <= RESP_OKAY;
            r_rlast    <= 1'b0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_aw_hs) begin
                        r_id       <= mem_nasti.awid;
                        r_addr     <= mem_nasti.awaddr;
                        r_len      <= mem_nasti.awlen;
                        r_burst    <= mem_nasti.awburst;
                        r_beat     <= '0;
                        r_err_dec  <= 1'b0;
                        r_err_last <= 1'b0;
                        r_prio_wr  <= 1'b0;
                    end else if (w_ar_hs) begin
                        r_id       <= mem_nasti.arid;
                        r_addr     <= mem_nasti.araddr;
                        r_len      <= mem_nasti.arlen;
                        r_burst    <= mem_nasti.arburst;
                        r_beat     <= '0;
                        r_prio_wr  <= 1'b1;
                    end
                end
                WR_DATA: begin
                    if (w_w_hs) begin
                        r_err_dec  <= w_err_dec_nx;
                        r_err_last <= w_err_last_nx;
                        if (w_last_beat) begin
                            r_bresp <= w_bresp_nx;
                        end else begin
                            r_beat <= r_beat + 8'd1;
                            r_addr <= w_addr_nx;
                        end
                    end
                end
                RD_FETCH: begin
                    r_rdata <= (w_legal && w_in_range) ? r_mem[w_idx] : '0;
                    r_rlast <= w_last_beat;
                    if (!w_legal) begin
                        r_rresp <= RESP_SLVERR;
                    end else if (!w_in_range) begin
                        r_rresp <= RESP_DECERR;
                    end else begin
                        r_rresp <= RESP_OKAY;
                    end
                end
                RD_DATA: begin
                    if (w_r_hs && !r_rlast) begin
                        r_beat <= r_beat + 8'd1;
                        r_addr <= w_addr_nx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Storage is deliberately left out of reset so contents survive a reset.
    always_ff @(posedge clk_asic) begin
        if (!rst_asic && w_w_hs && w_legal && w_in_range) begin
            for (int b = 0; b < 16; b++) begin
                if (mem_nasti.wstrb[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= mem_nasti.wdata[b*8 +: 8];
                end
            end
        end
    end

    assign mem_nasti.awready = w_awready;
    assign mem_nasti.arready = w_arready;
    assign mem_nasti.wready  = w_wready;
    assign mem_nasti.bvalid  = w_bvalid;
    assign mem_nasti.bid     = r_id;
    assign mem_nasti.bresp   = r_bresp;
    assign mem_nasti.buser   = 1'b0;
    assign mem_nasti.rvalid  = w_rvalid;
    assign mem_nasti.rid     = r_id;
    assign mem_nasti.rdata   = r_rdata;
    assign mem_nasti.rresp   = r_rresp;
    assign mem_nasti.rlast   = r_rlast;
    assign mem_nasti.ruser   = 1'b0;

    assign w_unused = ^{mem_nasti.awsize, mem_nasti.awuser, mem_nasti.awprot,
                        mem_nasti.awqos, mem_nasti.awregion, mem_nasti.awlock,
                        mem_nasti.awcache, mem_nasti.wuser, mem_nasti.arsize,
                        mem_nasti.aruser, mem_nasti.arprot, mem_nasti.arqos,
                        mem_nasti.arregion, mem_nasti.arlock, mem_nasti.arcache,
                        w_offset[31:IDX_W+4], w_offset[3:0]};

endmodule

// File: tb/tb_nasti_mem_responder.sv
// Directed bench for nasti_mem_responder: expected B/R responses are queued
// as stimulus is driven and compared as the responder produces them.
module tb_nasti_mem_responder;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nasti_mem_responder_if bus();

    nasti_mem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .clk_asic  (clk),
        .rst_asic  (rst),
        .mem_nasti (bus)
    );

    typedef struct packed {
        logic [7:0] id;
        logic [1:0] resp;
    } b_exp_t;

    typedef struct packed {
        logic [7:0]   id;
        logic [127:0] data;
        logic [1:0]   resp;
        logic         last;
    } r_exp_t;

    int checks = 0;
    int errors = 0;
    b_exp_t bq[$];
    r_exp_t rq[$];
    logic [127:0] model [int];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a >= BASE) && ((off >> 4) < 32'(DEPTH));
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) >> 4;
        return int'(off);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_send(input logic [7:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        bit ok = 0;
        bus.awvalid = 1'b1; bus.awid = id; bus.awaddr = addr;
        bus.awlen = len; bus.awburst = burst; bus.awsize = 3'd4;
        for (int i = 0; i < 64 && !ok; i++) begin
            #1;
            ok = bus.awready;
            @(posedge clk);
            #1;
        end
        bus.awvalid = 1'b0;
        check("aw_accept", ok, 1'b1);
    endtask

    task automatic ar_send(input logic [7:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        bit ok = 0;
        bus.arvalid = 1'b1; bus.arid = id; bus.araddr = addr;
        bus.arlen = len; bus.arburst = burst; bus.arsize = 3'd4;
        for (int i = 0; i < 64 && !ok; i++) begin
            #1;
            ok = bus.arready;
            @(posedge clk);
            #1;
        end
        bus.arvalid = 1'b0;
        check("ar_accept", ok, 1'b1);
    endtask

    task automatic w_send(input logic [127:0] data, input logic [15:0] strb, input logic last);
        bit ok = 0;
        bus.wvalid = 1'b1; bus.wdata = data; bus.wstrb = strb; bus.wlast = last;
        for (int i = 0; i < 64 && !ok; i++) begin
            #1;
            ok = bus.wready;
            @(posedge clk);
            #1;
        end
        bus.wvalid = 1'b0;
        check("w_accept", ok, 1'b1);
    endtask

    task automatic b_recv();
        bit got = 0;
        b_exp_t e;
        bus.bready = 1'b1;
        for (int i = 0; i < 64 && !got; i++) begin
            if (bus.bvalid) begin
                got = 1;
                if (bq.size() == 0) begin
                    check("b_unexpected", 1'b1, 1'b0);
                end else begin
                    e = bq.pop_front();
                    check("bid", bus.bid, e.id);
                    check("bresp", bus.bresp, e.resp);
                end
            end
            @(posedge clk);
            #1;
        end
        bus.bready = 1'b0;
        check("b_seen", got, 1'b1);
    endtask

    task automatic r_recv(input int n);
        r_exp_t e;
        bus.rready = 1'b1;
        for (int k = 0; k < n; k++) begin
            bit got = 0;
            for (int i = 0; i < 64 && !got; i++) begin
                if (bus.rvalid) begin
                    got = 1;
                    if (rq.size() == 0) begin
                        check("r_unexpected", 1'b1, 1'b0);
                    end else begin
                        e = rq.pop_front();
                        check("rid", bus.rid, e.id);
                        check("rdata", bus.rdata, e.data);
                        check("rresp", bus.rresp, e.resp);
                        check("rlast", bus.rlast, e.last);
                    end
                end
                @(posedge clk);
                #1;
            end
            check("r_seen", got, 1'b1);
        end
        bus.rready = 1'b0;
    endtask

    task automatic push_rd_exp(input logic [7:0] id, input logic [31:0] addr,
                               input logic [7:0] len, input logic [1:0] burst);
        r_exp_t e;
        logic [31:0] a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            e.id = id;
            e.last = (i == int'(len));
            if (burst > 2'b01) begin
                e.data = '0; e.resp = 2'b10;
            end else if (!in_range(a)) begin
                e.data = '0; e.resp = 2'b11;
            end else begin
                e.data = model[widx(a)]; e.resp = 2'b00;
            end
            rq.push_back(e);
            if (burst == 2'b01) a = a + 32'd16;
        end
    endtask

    task automatic rd_burst(input logic [7:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst, input bit chk_lat);
        push_rd_exp(id, addr, len, burst);
        ar_send(id, addr, len, burst);
        if (chk_lat) begin
            check("rd_lat_n1", bus.rvalid, 1'b0);
            tick();
            check("rd_lat_n2", bus.rvalid, 1'b1);
        end
        r_recv(int'(len) + 1);
    endtask

    task automatic wr_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [127:0] d0, input logic [15:0] strb,
                            input int early, input logic [1:0] exp_resp);
        b_exp_t be;
        logic [31:0] a = addr;
        logic [127:0] d, old;
        be.id = id; be.resp = exp_resp;
        bq.push_back(be);
        aw_send(id, addr, len, burst);
        for (int i = 0; i <= int'(len); i++) begin
            d = d0 + 128'(i);
            w_send(d, strb, (i == int'(len)) || (i == early));
            if (burst <= 2'b01 && in_range(a)) begin
                old = model.exists(widx(a)) ? model[widx(a)] : '0;
                for (int b = 0; b < 16; b++)
                    if (strb[b]) old[b*8 +: 8] = d[b*8 +: 8];
                model[widx(a)] = old;
            end
            if (burst == 2'b01) a = a + 32'd16;
        end
        b_recv();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0;
        bus.awburst = 0; bus.awuser = 0; bus.awprot = 0; bus.awqos = 0; bus.awregion = 0;
        bus.awlock = 0; bus.awcache = 0;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.wuser = 0;
        bus.bready = 0;
        bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0;
        bus.arburst = 0; bus.aruser = 0; bus.arprot = 0; bus.arqos = 0; bus.arregion = 0;
        bus.arlock = 0; bus.arcache = 0;
        bus.rready = 0;

        repeat (3) tick();
        check("rst_awready", bus.awready, 1'b1);
        check("rst_arready", bus.arready, 1'b1);
        check("rst_wready", bus.wready, 1'b0);
        check("rst_bvalid", bus.bvalid, 1'b0);
        check("rst_rvalid", bus.rvalid, 1'b0);
        check("rst_rlast", bus.rlast, 1'b0);
        check("rst_bid", bus.bid, 8'h00);
        check("rst_rid", bus.rid, 8'h00);
        check("rst_bresp", bus.bresp, 2'b00);
        check("rst_rresp", bus.rresp, 2'b00);
        check("rst_rdata", bus.rdata, 128'h0);
        rst = 1'b0;
        tick();

        // Collision straight after reset: write wins, pending read follows.
        bus.arvalid = 1'b1; bus.arid = 8'h21; bus.araddr = BASE + 32'h200;
        bus.arlen = 0; bus.arburst = 2'b01;
        bus.awvalid = 1'b1; bus.awid = 8'h20; bus.awaddr = BASE + 32'h200;
        bus.awlen = 0; bus.awburst = 2'b01;
        #1;
        check("col1_awready", bus.awready, 1'b1);
        check("col1_arready", bus.arready, 1'b0);
        wr_burst(8'h20, BASE + 32'h200, 8'd0, 2'b01, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666,
                 16'hFFFF, -1, 2'b00);
        check("pend_arready", bus.arready, 1'b1);
        check("pend_awready", bus.awready, 1'b0);
        rd_burst(8'h21, BASE + 32'h200, 8'd0, 2'b01, 1'b0);

        bus.arvalid = 1'b1; bus.arid = 8'h23; bus.araddr = BASE + 32'h200;
        bus.arlen = 0; bus.arburst = 2'b01;
        bus.awvalid = 1'b1;
        #1;
        check("col2_awready", bus.awready, 1'b1);
        check("col2_arready", bus.arready, 1'b0);
        wr_burst(8'h22, BASE + 32'h200, 8'd0, 2'b01, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                 16'hFFFF, -1, 2'b00);
        rd_burst(8'h23, BASE + 32'h200, 8'd0, 2'b01, 1'b0);

        // Write then read four INCR beats, with the AR-to-rvalid latency.
        wr_burst(8'h03, BASE, 8'd3, 2'b01, 128'hDEAD_BEEF_0000_0001_CAFE_F00D_0000_0100,
                 16'hFFFF, -1, 2'b00);
        rd_burst(8'h04, BASE, 8'd3, 2'b01, 1'b1);

        // Partial strobe.
        wr_burst(8'h05, BASE + 32'h40, 8'd0, 2'b01, {128{1'b1}}, 16'hFFFF, -1, 2'b00);
        wr_burst(8'h06, BASE + 32'h40, 8'd0, 2'b01, 128'h0, 16'h000F, -1, 2'b00);
        push_rd_exp(8'h07, BASE + 32'h40, 8'd0, 2'b01);
        check("partial_model", rq[0].data, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0000);
        ar_send(8'h07, BASE + 32'h40, 8'd0, 2'b01);
        r_recv(1);

        // Out-of-range read (FIXED below base) and write one past the top.
        rd_burst(8'h08, 32'h7FFF_FFF0, 8'd1, 2'b00, 1'b0);
        wr_burst(8'h09, BASE + 32'(16 * DEPTH), 8'd0, 2'b01, 128'h5555, 16'hFFFF, -1, 2'b11);
        rd_burst(8'h0A, BASE, 8'd0, 2'b01, 1'b0);

        // Read backpressure: first beat held for five cycles.
        push_rd_exp(8'h0B, BASE, 8'd1, 2'b01);
        ar_send(8'h0B, BASE, 8'd1, 2'b01);
        got = 0;
        for (int i = 0; i < 16 && !got; i++) begin
            if (bus.rvalid) got = 1; else tick();
        end
        check("bp_rvalid_seen", got, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check("bp_rvalid", bus.rvalid, 1'b1);
            check("bp_rdata", bus.rdata, rq[0].data);
            check("bp_rlast", bus.rlast, rq[0].last);
            tick();
        end
        r_recv(2);

        // Early wlast, illegal write burst, illegal read burst, FIXED write.
        wr_burst(8'h0C, BASE + 32'h80, 8'd2, 2'b01, 128'h1000_2000_3000, 16'hFFFF, 0, 2'b10);
        rd_burst(8'h0D, BASE + 32'h80, 8'd2, 2'b01, 1'b0);
        wr_burst(8'h0E, BASE, 8'd0, 2'b10, 128'h9999_9999, 16'hFFFF, -1, 2'b10);
        rd_burst(8'h0F, BASE, 8'd0, 2'b01, 1'b0);
        rd_burst(8'h10, BASE, 8'd0, 2'b11, 1'b0);
        wr_burst(8'h11, BASE + 32'hC0, 8'd1, 2'b00, 128'h7777_0000, 16'hFFFF, -1, 2'b00);
        rd_burst(8'h12, BASE + 32'hC0, 8'd0, 2'b01, 1'b0);

        // Maximum burst length.
        wr_burst(8'h13, BASE + 32'h1000, 8'd255, 2'b01, 128'hABCD_0000_0000, 16'hFFFF, -1, 2'b00);
        rd_burst(8'h14, BASE + 32'h1000, 8'd255, 2'b01, 1'b0);

        // Reset while the second beat of an eight-beat read is on the bus.
        ar_send(8'h15, BASE, 8'd7, 2'b01);
        bus.rready = 1'b1;
        got = 0;
        for (int i = 0; i < 16 && !got; i++) begin
            if (bus.rvalid) got = 1; else tick();
        end
        tick();
        bus.rready = 1'b0;
        got = 0;
        for (int i = 0; i < 16 && !got; i++) begin
            if (bus.rvalid) got = 1; else tick();
        end
        check("mid_beat2_valid", got, 1'b1);
        rst = 1'b1;
        tick();
        check("mid_rst_rvalid", bus.rvalid, 1'b0);
        check("mid_rst_rlast", bus.rlast, 1'b0);
        check("mid_rst_rdata", bus.rdata, 128'h0);
        check("mid_rst_awready", bus.awready, 1'b1);
        rst = 1'b0;
        tick();
        rd_burst(8'h16, BASE, 8'd3, 2'b01, 1'b1);

        check("rq_empty", rq.size(), 0);
        check("bq_empty", bq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nasti_mem_responder.md
NASTI_MEM_RESPONDER -- requirements
Module: nasti_mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_BASE, default 32'h8000_0000, meaning the byte address of memory word 0.
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 128-bit storage words (power of two).
REQ-003 The block SHALL have port clk_asic  in  1  as its single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_asic  in  1  as its reset; reset is synchronous and active-high.
REQ-005 The block SHALL have these AW ports: mem_nasti_awvalid in 1; mem_nasti_awready out 1; awid in 8; awaddr in 32; awlen in 8; awsize in 3; awburst in 2. awuser, awprot, awqos, awregion, awlock and awcache are inputs and are ignored.
REQ-006 The block SHALL have these W ports: mem_nasti_wvalid in 1; wready out 1; wdata in 128; wstrb in 16; wlast in 1. wuser is an input and is ignored.
REQ-007 The block SHALL have these B ports: mem_nasti_bvalid out 1; bready in 1; bid out 8; bresp out 2; buser out 1 (constant 0).
REQ-008 The block SHALL have these AR ports: mem_nasti_arvalid in 1; arready out 1; arid in 8; araddr in 32; arlen in 8; arsize in 3; arburst in 2. aruser, arprot, arqos, arregion, arlock and arcache are inputs and are ignored.
REQ-009 The block SHALL have these R ports: mem_nasti_rvalid out 1; rready in 1; rid out 8; rdata out 128; rresp out 2; rlast out 1; ruser out 1 (constant 0).

Function
REQ-010 The FSM SHALL have states IDLE, WR_DATA, WR_RESP, RD_FETCH and RD_DATA; one transaction is outstanding at a time.
REQ-011 In IDLE, with prio_wr=1: awready=1 and arready=!awvalid. With prio_wr=0: arready=1 and awready=!arvalid. awready and arready SHALL be 0 in every other state.
REQ-012 An AW handshake SHALL latch id, addr, len and burst, clear the error flags, set prio_wr=0 and go to WR_DATA. An AR handshake SHALL latch the same fields, set prio_wr=1 and go to RD_FETCH.
REQ-013 Beat address SHALL be computed as follows: INCR (01) adds 16 per beat; FIXED (00) holds the address; address bits [3:0] are ignored; awsize/arsize are ignored.
REQ-014 A beat SHALL be in range iff addr>=ADDR_BASE and ((addr-ADDR_BASE)>>4)<DEPTH_WORDS, computed in 32-bit unsigned arithmetic.
REQ-015 In WR_DATA, wready SHALL be 1. Each accepted beat SHALL write the bytes enabled by wstrb at that beat's word, only if the beat is in range and the burst is INCR or FIXED.
REQ-016 WR_DATA SHALL end on the beat where beat count == awlen, independent of wlast.
REQ-017 bresp SHALL be chosen by this priority: WRAP/reserved burst -> SLVERR(10); any out-of-range beat -> DECERR(11); wlast mismatch on any beat -> SLVERR; otherwise OKAY(00).
REQ-018 In WR_RESP, bvalid=1 and bid=latched id, held stable until bready; the handshake SHALL return the FSM to IDLE.
REQ-019 RD_FETCH SHALL register the word at the current beat address into rdata and then go to RD_DATA. An out-of-range beat or illegal burst SHALL give rdata=0.
REQ-020 In RD_DATA, rvalid=1, rid=latched id, rlast=(beat==arlen), and rresp=SLVERR for an illegal burst, DECERR for an out-of-range beat, else OKAY. These are per beat and held stable while rready=0.
REQ-021 An R handshake on the last beat SHALL go to IDLE; otherwise it SHALL advance the address and go to RD_FETCH, giving one beat per 2 cycles minimum.
REQ-022 Read-to-data latency SHALL be: AR handshake at cycle N -> rvalid first high at cycle N+2.
REQ-023 awlen/arlen=255 SHALL give 256 beats; the 8-bit beat counter SHALL not wrap before the end compare.

Reset
REQ-024 On rst_asic=1 at a clock edge: state=IDLE and prio_wr=1. bvalid, rvalid, rlast and wready SHALL be 0; bid, rid, bresp, rresp and rdata SHALL be 0.
REQ-025 Reset in mid-burst SHALL abandon the transaction with no response issued; memory contents SHALL not be reset.

Verification
REQ-026 Write then read: AW INCR addr 0x8000_0000 len 3, four W beats with wstrb 0xFFFF -> bresp 00; AR of the same range -> 4 beats of matching data, rlast only on beat 4, rresp 00.
REQ-027 Partial strobe: write 0xFF..FF, then write 0x00..00 with wstrb 0x000F -> read returns 0xFF..FF_0000_0000.
REQ-028 Simultaneous AW and AR in IDLE after reset -> write granted first; after it completes, the pending AR is granted; a second collision grants the write.
REQ-029 Out of range: AR addr 0x7FFF_FFF0 len 1 -> two beats with rdata 0 and rresp 11. AW at ADDR_BASE+16*DEPTH_WORDS -> bresp 11, and memory is unchanged.
REQ-030 Backpressure and errors: rready=0 for 5 cycles -> rvalid, rdata and rlast remain stable. wlast early on beat 1 of len 2 -> burst still takes 3 beats, bresp 10. awburst 10 -> bresp 10, no write.
REQ-031 Reset asserted during beat 2 of a len 7 read -> rvalid 0 the next cycle, and the next AR is served normally.
